// File: rtl/imgsens_pkg.sv
// -----------------------------------------------------------------------------
// imgsens_pkg
// Shared definitions for the image sensor capture block:
//   - default values for DATA_W, FRAME_DEPTH and TIMEOUT_CYCLES
//   - the capture FSM state type
// Build option: IMGSENS_TIMEOUT_EN adds the ABORT state, which is reached
// when the watchdog expires.
// -----------------------------------------------------------------------------
package imgsens_pkg;

  localparam int DEFAULT_DATA_W         = 9;
  localparam int DEFAULT_FRAME_DEPTH    = 64;
  localparam int DEFAULT_TIMEOUT_CYCLES = 256;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
`ifdef IMGSENS_TIMEOUT_EN
    ,
    ST_ABORT   = 2'd3
`endif
  } state_e;

endpackage

// File: rtl/imgsens_watchdog.sv
// -----------------------------------------------------------------------------
// imgsens_watchdog
// Idle-cycle watchdog for the capture FSM. The counter restarts on clear_i and
// advances on each enabled cycle. expired_o is raised combinationally in the
// cycle that would take the count to TIMEOUT_CYCLES, so the FSM reacts
// exactly TIMEOUT_CYCLES cycles after the last clear.
// Only instantiated when IMGSENS_TIMEOUT_EN is defined.
// Ports:
//   clk_i     rising-edge clock
//   rst_n_i   asynchronous active-low reset
//   clear_i   restart the idle count (capture start / pixel seen)
//   enable_i  count this cycle (FSM is capturing)
//   expired_o idle limit reached this cycle
// -----------------------------------------------------------------------------
module imgsens_watchdog #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expired_o = enable_i && !clear_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || expired_o) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/image_sensor_capture.sv
// -----------------------------------------------------------------------------
// image_sensor_capture
// Captures one frame of pixels from an image sensor model into a register
// file. A capture request starts the sensor, each valid pixel is written at
// the next free address (one cycle registered latency), and the frame ends
// either on the last pixel or on the sensor's end-of-frame indication.
// Build option: IMGSENS_TIMEOUT_EN adds an idle watchdog (imgsens_watchdog)
// that aborts a stalled capture with an out_error pulse.
// Ports:
//   in_clk, in_rst_n    clock, asynchronous active-low reset
//   in_start            capture request (honoured in IDLE only)
//   in_pixel(_valid)    pixel stream from the sensor
//   in_imgsensor_done   sensor end-of-frame
//   out_frame_capture   one-cycle start pulse to the sensor
//   out_write_en/out_data_addr/out_data   register-file write port
//   out_busy            capture in progress
//   out_done            one-cycle frame-complete pulse
//   out_short_frame     frame ended before FRAME_DEPTH pixels (sticky)
//   out_pixel_count     pixels written in the last frame
//   out_error           one-cycle timeout-abort pulse
// -----------------------------------------------------------------------------
module image_sensor_capture
  import imgsens_pkg::*;
#(
  parameter int  DATA_W         = DEFAULT_DATA_W,
  parameter int  FRAME_DEPTH    = DEFAULT_FRAME_DEPTH,
  parameter int  TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  localparam int ADDR_W         = $clog2(FRAME_DEPTH)
) (
  input  logic              in_clk,
  input  logic              in_rst_n,
  input  logic              in_start,
  input  logic [DATA_W-1:0] in_pixel,
  input  logic              in_pixel_valid,
  input  logic              in_imgsensor_done,
  output logic              out_frame_capture,
  output logic              out_write_en,
  output logic [ADDR_W-1:0] out_data_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_busy,
  output logic              out_done,
  output logic              out_short_frame,
  output logic [ADDR_W:0]   out_pixel_count,
  output logic              out_error
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_DEPTH - 1);

  // Elaboration-time guard against unsupported configurations.
  if (FRAME_DEPTH < 2 || FRAME_DEPTH > 4096 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("image_sensor_capture: FRAME_DEPTH must be 2..4096 and TIMEOUT_CYCLES >= 1");
  end

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              frame_capture_q;
  logic              write_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              busy_q;
  logic              done_q;
  logic              short_q;
  logic [CNT_W-1:0]  pixel_count_q;

  // Count including a pixel accepted this cycle, so a frame closing on a
  // valid pixel reports that pixel too.
  logic [CNT_W-1:0]  pixel_count_d;
  logic              last_pixel;

  assign pixel_count_d = cnt_q + CNT_W'(in_pixel_valid);
  assign last_pixel    = in_pixel_valid && (cnt_q == LAST_IDX);

`ifdef IMGSENS_TIMEOUT_EN
  logic error_q;
  logic wd_clear;
  logic wd_enable;
  logic wd_expired;

  assign wd_clear  = ((state_q == ST_IDLE) && in_start) || in_pixel_valid;
  assign wd_enable = (state_q == ST_CAPTURE);

  imgsens_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (in_clk),
    .rst_n_i  (in_rst_n),
    .clear_i  (wd_clear),
    .enable_i (wd_enable),
    .expired_o(wd_expired)
  );

  assign out_error = error_q;
`else
  assign out_error = 1'b0;
`endif

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      frame_capture_q <= 1'b0;
      write_en_q      <= 1'b0;
      addr_q          <= '0;
      data_q          <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      short_q         <= 1'b0;
      pixel_count_q   <= '0;
`ifdef IMGSENS_TIMEOUT_EN
      error_q         <= 1'b0;
`endif
    end else begin
      // Pulses and the write port default low; address/data read as zero
      // whenever no write is presented.
      frame_capture_q <= 1'b0;
      write_en_q      <= 1'b0;
      addr_q          <= '0;
      data_q          <= '0;
      done_q          <= 1'b0;
`ifdef IMGSENS_TIMEOUT_EN
      error_q         <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (in_start) begin
            state_q         <= ST_CAPTURE;
            frame_capture_q <= 1'b1;
            cnt_q           <= '0;
            short_q         <= 1'b0;
            busy_q          <= 1'b1;
          end
        end

        ST_CAPTURE: begin
          if (in_pixel_valid) begin
            write_en_q <= 1'b1;
            addr_q     <= cnt_q[ADDR_W-1:0];
            data_q     <= in_pixel;
            cnt_q      <= cnt_q + CNT_W'(1);
          end
          // Entering DONE together with registering the final write makes
          // out_done coincide with the last out_write_en.
          if (last_pixel || in_imgsensor_done) begin
            state_q       <= ST_DONE;
            done_q        <= 1'b1;
            pixel_count_q <= pixel_count_d;
            short_q       <= !last_pixel;
          end
`ifdef IMGSENS_TIMEOUT_EN
          else if (wd_expired) begin
            state_q       <= ST_ABORT;
            error_q       <= 1'b1;
            pixel_count_q <= cnt_q;
          end
`endif
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end

`ifdef IMGSENS_TIMEOUT_EN
        ST_ABORT: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
`endif

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_frame_capture = frame_capture_q;
  assign out_write_en      = write_en_q;
  assign out_data_addr     = addr_q;
  assign out_data          = data_q;
  assign out_busy          = busy_q;
  assign out_done          = done_q;
  assign out_short_frame   = short_q;
  assign out_pixel_count   = pixel_count_q;

endmodule

// File: tb/tb_image_sensor_capture.sv
module tb_image_sensor_capture;

  localparam int DW  = 9;
  localparam int FD  = 64;
  localparam int AW  = 6;
  localparam int TO  = 16;
  localparam int DW2 = 12;
  localparam int FD2 = 256;
  localparam int AW2 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default widths, short timeout
  logic          rst_n, start, pv, sdone;
  logic [DW-1:0] pix;
  logic          fc, we, busy, done, shrt, err;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic [AW:0]   pcnt;

  // DUT B: 12-bit pixels, 256-pixel frame
  logic           start2, pv2, sdone2;
  logic [DW2-1:0] pix2;
  logic           fc2, we2, busy2, done2, shrt2, err2;
  logic [AW2-1:0] addr2;
  logic [DW2-1:0] data2;
  logic [AW2:0]   pcnt2;

  image_sensor_capture #(.DATA_W(DW), .FRAME_DEPTH(FD), .TIMEOUT_CYCLES(TO)) u_dut (
    .in_clk(clk), .in_rst_n(rst_n), .in_start(start), .in_pixel(pix),
    .in_pixel_valid(pv), .in_imgsensor_done(sdone),
    .out_frame_capture(fc), .out_write_en(we), .out_data_addr(addr), .out_data(data),
    .out_busy(busy), .out_done(done), .out_short_frame(shrt),
    .out_pixel_count(pcnt), .out_error(err)
  );

  image_sensor_capture #(.DATA_W(DW2), .FRAME_DEPTH(FD2), .TIMEOUT_CYCLES(TO)) u_dut_big (
    .in_clk(clk), .in_rst_n(rst_n), .in_start(start2), .in_pixel(pix2),
    .in_pixel_valid(pv2), .in_imgsensor_done(sdone2),
    .out_frame_capture(fc2), .out_write_en(we2), .out_data_addr(addr2), .out_data(data2),
    .out_busy(busy2), .out_done(done2), .out_short_frame(shrt2),
    .out_pixel_count(pcnt2), .out_error(err2)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Output monitors, sampled 1 time unit after the rising edge.
  int wr_addr_q[$], wr_data_q[$];
  int done_n, fc_n, err_n, stray_n, done_we, done_short, done_pcnt, err_pcnt;
  int wr2_addr_q[$], wr2_data_q[$];
  int done2_n, done2_pcnt, done2_short, err2_n;

  always @(posedge clk) begin
    #1;
    if (we === 1'b1) begin
      wr_addr_q.push_back(int'(addr));
      wr_data_q.push_back(int'(data));
    end else if (addr !== '0 || data !== '0) begin
      stray_n++;
    end
    if (done === 1'b1) begin
      done_n++;
      done_we    = int'(we);
      done_short = int'(shrt);
      done_pcnt  = int'(pcnt);
    end
    if (fc === 1'b1) fc_n++;
    if (err === 1'b1) begin
      err_n++;
      err_pcnt = int'(pcnt);
    end
    if (we2 === 1'b1) begin
      wr2_addr_q.push_back(int'(addr2));
      wr2_data_q.push_back(int'(data2));
    end
    if (done2 === 1'b1) begin
      done2_n++;
      done2_pcnt  = int'(pcnt2);
      done2_short = int'(shrt2);
    end
    if (err2 === 1'b1) err2_n++;
  end

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_n = 0; fc_n = 0; err_n = 0; stray_n = 0;
    done_we = -1; done_short = -1; done_pcnt = -1; err_pcnt = -1;
  endtask

  // Reference: the k-th accepted pixel lands at address k; the frame holds
  // min(pixels sent, FD) pixels and is short when it closes before FD.
  // gap_mode: 0 back-to-back, 1 one valid every 3 cycles, 2 random gaps.
  task automatic run_frame(input string name, input int npix, input int gap_mode,
                           input bit sensor_done, input bit done_with_last,
                           input bit index_data, input bit poke_start);
    int exp_q[$];
    int to;
    int g;
    int n;
    clear_mon();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({name, " busy_after_start"}, busy, 1);
    for (int i = 0; i < npix; i++) begin
      g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 2 : int'($urandom_range(0, 3));
      repeat (g) @(negedge clk);
      pv  = 1'b1;
      pix = index_data ? DW'(i) : DW'($urandom);
      exp_q.push_back(int'(pix));
      if (poke_start && i == 5) start = 1'b1;
      if (done_with_last && i == npix - 1) sdone = 1'b1;
      @(negedge clk);
      pv = 1'b0; start = 1'b0; sdone = 1'b0;
    end
    if (sensor_done && !done_with_last) begin
      repeat (2) @(negedge clk);
      sdone = 1'b1;
      @(negedge clk);
      sdone = 1'b0;
    end
    to = 0;
    while (done_n == 0 && to < 20) begin
      @(negedge clk);
      to++;
    end
    repeat (2) @(negedge clk);
    check({name, " done_pulses"}, done_n, 1);
    check({name, " start_pulses"}, fc_n, 1);
    check({name, " write_count"}, wr_addr_q.size(), npix);
    n = (wr_addr_q.size() < npix) ? wr_addr_q.size() : npix;
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s addr[%0d]", name, k), wr_addr_q[k], k);
      check($sformatf("%s data[%0d]", name, k), wr_data_q[k], exp_q[k]);
    end
    check({name, " short_frame"}, done_short, (npix < FD) ? 1 : 0);
    check({name, " pixel_count"}, done_pcnt, npix);
    check({name, " write_with_done"}, done_we, (npix == FD || done_with_last) ? 1 : 0);
    check({name, " idle_port_zero"}, stray_n, 0);
    check({name, " no_error"}, err_n, 0);
    check({name, " busy_after_done"}, busy, 0);
    $display("frame %s: pixels=%0d writes=%0d count=%0d short=%0d", name, npix,
             wr_addr_q.size(), done_pcnt, done_short);
  endtask

  initial begin
    int t;
    rst_n = 1'b0; start = 1'b0; pv = 1'b0; sdone = 1'b0; pix = '0;
    start2 = 1'b0; pv2 = 1'b0; sdone2 = 1'b0; pix2 = '0;
    clear_mon();
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset write_en", we, 0);
    check("reset addr", addr, 0);
    check("reset data", data, 0);
    check("reset done", done, 0);
    check("reset short", shrt, 0);
    check("reset pixel_count", pcnt, 0);
    check("reset error", err, 0);
    check("reset frame_capture", fc, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame("full_index",   FD, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_frame("gap3",         FD, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame("random_gaps",  FD, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame("short20",      20, 0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a capture, with short/pixel_count still set.
    clear_mon();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      pv = 1'b1; pix = DW'($urandom);
      @(negedge clk);
    end
    pv = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midreset busy", busy, 0);
    check("midreset short", shrt, 0);
    check("midreset pixel_count", pcnt, 0);
    check("midreset write_en", we, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("midreset no_done", done_n, 0);
    check("midreset no_error", err_n, 0);
    $display("reset mid-capture after 30 pixels: done=%0d error=%0d", done_n, err_n);
    run_frame("after_reset",   FD, 0, 1'b0, 1'b0, 1'b1, 1'b0);

    run_frame("short_same",    13, 2, 1'b1, 1'b1, 1'b0, 1'b0);
    run_frame("last_and_done", FD, 0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Pixels and end-of-frame while idle are ignored.
    clear_mon();
    for (int i = 0; i < 5; i++) begin
      pv = 1'b1; pix = DW'($urandom); sdone = (i == 2);
      @(negedge clk);
    end
    pv = 1'b0; sdone = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_pixels writes", wr_addr_q.size(), 0);
    check("idle_pixels done", done_n, 0);
    check("idle_pixels busy", busy, 0);
    $display("idle pixels: writes=%0d done=%0d", wr_addr_q.size(), done_n);

    // Sensor stalls after 10 pixels.
    clear_mon();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pv = 1'b1; pix = DW'($urandom);
      @(negedge clk);
    end
    pv = 1'b0;
    t = 0;
    while (err_n == 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
`ifdef IMGSENS_TIMEOUT_EN
    check("timeout latency", t, TO);
    repeat (3) @(negedge clk);
    check("timeout error_pulses", err_n, 1);
    check("timeout no_done", done_n, 0);
    check("timeout pixel_count", err_pcnt, 10);
    check("timeout busy", busy, 0);
    check("timeout writes", wr_addr_q.size(), 10);
    $display("timeout: latency=%0d errors=%0d count=%0d", t, err_n, err_pcnt);
`else
    check("stall no_error", err_n, 0);
    check("stall busy", busy, 1);
    check("stall no_done", done_n, 0);
    sdone = 1'b1;
    @(negedge clk);
    sdone = 1'b0;
    repeat (3) @(negedge clk);
    check("stall done", done_n, 1);
    check("stall pixel_count", done_pcnt, 10);
    check("stall short", done_short, 1);
    $display("stall: waited=%0d done=%0d count=%0d", t, done_n, done_pcnt);
`endif

    // Wide configuration: 256 back-to-back random pixels.
    begin
      int exp2_q[$];
      int n2;
      wr2_addr_q.delete(); wr2_data_q.delete();
      done2_n = 0; done2_pcnt = -1; done2_short = -1; err2_n = 0;
      @(negedge clk); start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
      for (int i = 0; i < FD2; i++) begin
        pv2 = 1'b1; pix2 = DW2'($urandom);
        exp2_q.push_back(int'(pix2));
        @(negedge clk);
      end
      pv2 = 1'b0;
      t = 0;
      while (done2_n == 0 && t < 20) begin
        @(negedge clk);
        t++;
      end
      repeat (2) @(negedge clk);
      check("wide write_count", wr2_addr_q.size(), FD2);
      n2 = (wr2_addr_q.size() < FD2) ? wr2_addr_q.size() : FD2;
      for (int k = 0; k < n2; k++) begin
        check($sformatf("wide addr[%0d]", k), wr2_addr_q[k], k);
        check($sformatf("wide data[%0d]", k), wr2_data_q[k], exp2_q[k]);
      end
      check("wide done", done2_n, 1);
      check("wide pixel_count", done2_pcnt, FD2);
      check("wide short", done2_short, 0);
      check("wide no_error", err2_n, 0);
      check("wide busy", busy2, 0);
      $display("wide frame: writes=%0d count=%0d short=%0d", wr2_addr_q.size(), done2_pcnt, done2_short);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
